// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: buffers ADC samples in a small FIFO, frames them into
// FFT_LEN-point Avalon-ST packets (sop/eop/valid) and drives the FFT core sink
// under sink_ready backpressure.
// Optional build macro: FEEDER_OFFSET_BIN_EN -- when defined, adc_data is offset
// binary and is converted to two's complement by inverting the MSB.
// A write attempt that finds no room (including the frame-starting sample in
// IDLE) is dropped and flags fifo_ovf.
module fft_frame_feeder #(
  parameter int DATA_W     = 12,
  parameter int FFT_LEN    = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              frame_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              ovf_clr,
  input  logic              sink_ready,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic              sink_valid,
  output logic [1:0]        sink_error,
  output logic              frame_done,
  output logic              fifo_ovf,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FFT_LEN);
  localparam logic [CW-1:0] LAST = {CW{1'b1}};          // FFT_LEN-1 (power of two)
  localparam logic [AW:0]   FULL = {1'b1, {AW{1'b0}}};  // FIFO_DEPTH (power of two)

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [CW-1:0]     in_cnt, out_cnt;
  logic [DATA_W-1:0] sample;
  logic              xfer, fifo_rd, room;
  logic              wr_try, fifo_wr, drop;

`ifdef FEEDER_OFFSET_BIN_EN
  assign sample = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
`else
  assign sample = adc_data;
`endif

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write
  // when the output stage is pulling from it.
  assign xfer    = sink_valid && sink_ready;
  assign fifo_rd = (count != '0) && (!sink_valid || sink_ready);
  assign room    = (count != FULL) || fifo_rd;

  // State register for the input framing FSM.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values, whatever the block order.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a frame opens on the first accepted sample with frame_en high
  // and closes on its FFT_LEN-th accepted sample.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_wr) state_nxt = RUN;
      RUN:     if (fifo_wr && in_cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: which samples are written and which are dropped on overflow.
  always_comb begin
    wr_try  = adc_valid && (state == RUN || frame_en);
    fifo_wr = wr_try && room;
    drop    = wr_try && !room;
  end

  // Input sample counter; wraps to 0 on the frame's last write.
  always_ff @(posedge clk_50m) begin
    if (!rst_n)       in_cnt <= '0;
    else if (fifo_wr) in_cnt <= (state == IDLE) ? CW'(1) : in_cnt + 1'b1;
  end

  // FIFO storage.
  // NOTE: the sample array is deliberately not reset; pointers and count alone
  // define which entries are live.
  always_ff @(posedge clk_50m) begin
    if (fifo_wr) mem[wr_ptr] <= sample;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output register stage: held while stalled, reloaded from the FIFO head when
  // empty or when the current word transfers.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      sink_valid <= 1'b0;
      sink_real  <= '0;
      out_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (fifo_rd) begin
        sink_valid <= 1'b1;
        sink_real  <= mem[rd_ptr];
      end else if (xfer) begin
        sink_valid <= 1'b0;
      end
      if (xfer) out_cnt <= out_cnt + 1'b1;
      frame_done <= xfer && (out_cnt == LAST);
    end
  end

  // Sticky overflow flag; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk_50m) begin
    if (!rst_n)       fifo_ovf <= 1'b0;
    else if (drop)    fifo_ovf <= 1'b1;
    else if (ovf_clr) fifo_ovf <= 1'b0;
  end

  assign sink_imag  = '0;
  assign sink_error = 2'b00;
  assign sink_sop   = sink_valid && (out_cnt == '0);
  assign sink_eop   = sink_valid && (out_cnt == LAST);
  assign busy       = (state == RUN) || (count != '0) || sink_valid;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: a queue-level model predicts every
// output each cycle; directed tests add hand-computed frame expectations.
module tb_fft_frame_feeder;

  localparam int DATA_W     = 12;
  localparam int FFT_LEN    = 128;
  localparam int FIFO_DEPTH = 16;

  logic              clk_50m = 1'b0;
  logic              rst_n, frame_en, adc_valid, ovf_clr, sink_ready;
  logic [DATA_W-1:0] adc_data, sink_real, sink_imag;
  logic              sink_sop, sink_eop, sink_valid, frame_done, fifo_ovf, busy;
  logic [1:0]        sink_error;

  int vectors     = 0;
  int miscompares = 0;

  fft_frame_feeder #(.DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .frame_en(frame_en), .adc_data(adc_data),
    .adc_valid(adc_valid), .ovf_clr(ovf_clr), .sink_ready(sink_ready),
    .sink_real(sink_real), .sink_imag(sink_imag), .sink_sop(sink_sop),
    .sink_eop(sink_eop), .sink_valid(sink_valid), .sink_error(sink_error),
    .frame_done(frame_done), .fifo_ovf(fifo_ovf), .busy(busy)
  );

  always #10 clk_50m = ~clk_50m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected two's complement value of a raw ADC word.
  function automatic logic [DATA_W-1:0] conv(input logic [DATA_W-1:0] d);
`ifdef FEEDER_OFFSET_BIN_EN
    return d ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
    return d;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_real;
  bit                m_valid, m_run, m_ovf, m_done, started;
  int                m_cnt, m_in, cyc;

  task automatic model_step();
    bit xfer, rd, room, attempt;
    if (!rst_n) begin
      q.delete();
      m_valid = 0; m_real = '0; m_cnt = 0; m_in = 0;
      m_run = 0; m_ovf = 0; m_done = 0; started = 1;
      return;
    end
    xfer    = m_valid && sink_ready;
    rd      = (q.size() != 0) && (!m_valid || xfer);
    room    = (q.size() < FIFO_DEPTH) || rd;
    attempt = adc_valid && (m_run || frame_en);
    m_done  = xfer && (m_cnt == FFT_LEN - 1);
    if (xfer) m_cnt = (m_cnt + 1) % FFT_LEN;
    if (rd) begin
      m_real  = q.pop_front();
      m_valid = 1;
    end else if (xfer) begin
      m_valid = 0;
    end
    if (attempt && room) begin
      q.push_back(conv(adc_data));
      if (!m_run) m_in = 0;
      m_in++;
      m_run = (m_in < FFT_LEN);
    end
    if (attempt && !room) m_ovf = 1;
    else if (ovf_clr)     m_ovf = 0;
  endtask

  initial forever begin
    @(posedge clk_50m);
    cyc++;
    model_step();
  end

  // ---------------- compare process + frame statistics ----------------
  int                tx_cnt, eop_cyc, done_cyc, first_valid_cyc;
  bit                got_sop;
  logic [DATA_W-1:0] first_sop, last_eop;

  initial forever begin
    @(negedge clk_50m);
    if (started) begin
      check("sink_valid", sink_valid, m_valid);
      if (m_valid) begin
        check("sink_real", sink_real, m_real);
        check("sink_sop", sink_sop, m_cnt == 0);
        check("sink_eop", sink_eop, m_cnt == FFT_LEN - 1);
      end
      check("sink_imag", sink_imag, 0);
      check("sink_error", sink_error, 0);
      check("frame_done", frame_done, m_done);
      check("fifo_ovf", fifo_ovf, m_ovf);
      check("busy", busy, m_run || q.size() != 0 || m_valid);
      if (sink_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (frame_done) done_cyc = cyc;
      if (sink_valid && sink_ready && rst_n) begin
        tx_cnt++;
        if (sink_sop && !got_sop) begin
          first_sop = sink_real;
          got_sop   = 1;
        end
        if (sink_eop) begin
          last_eop = sink_real;
          eop_cyc  = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_50m);
    #2;
  endtask

  task automatic clear_stats();
    tx_cnt = 0; got_sop = 0; first_sop = '0; last_eop = '0;
    eop_cyc = -1; done_cyc = -1; first_valid_cyc = -1;
  endtask

  task automatic ramp(input int n, input int start, input bit en);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = DATA_W'(start + i);
      frame_en  = en;
      tick();
    end
    adc_valid = 1'b0;
    frame_en  = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    adc_valid  = 1'b0;
    sink_ready = 1'b1;
    while ((busy || sink_valid) && n < budget) begin
      tick();
      n++;
    end
    check(name, n < budget, 1);
    tick();
    tick();
  endtask

  task automatic frame_checks(input string tag, input int n, input int sop_v, input int eop_v);
    check({tag, "_tx_count"}, tx_cnt, n);
    check({tag, "_sop_value"}, first_sop, conv(DATA_W'(sop_v)));
    check({tag, "_eop_value"}, last_eop, conv(DATA_W'(eop_v)));
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; frame_en = 1'b0; adc_valid = 1'b0; adc_data = '0;
    ovf_clr = 1'b0; sink_ready = 1'b0;
    clear_stats();
    tick();
    tick();
    check("rst_sink_valid", sink_valid, 0);
    check("rst_sop_eop", {sink_sop, sink_eop}, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_fifo_ovf", fifo_ovf, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Test 1: continuous ramp, sink always ready.
    clear_stats();
    sink_ready = 1'b1;
    t0 = cyc;
    ramp(128, 0, 1'b1);
    drain("t1_drain", 400);
    frame_checks("t1", 128, 0, 127);
    check("t1_latency", first_valid_cyc - t0, 2);
    check("t1_done_delay", done_cyc - eop_cyc, 1);

    // Test 2: sink_ready 4 low / 4 high, samples paced every other cycle.
    clear_stats();
    for (int i = 0; i < 256; i++) begin
      sink_ready = (i % 8) >= 4;
      frame_en   = 1'b1;
      adc_valid  = (i % 2) == 0;
      adc_data   = DATA_W'(i / 2);
      tick();
    end
    drain("t2_drain", 400);
    frame_checks("t2", 128, 0, 127);
    check("t2_no_ovf", fifo_ovf, 0);

    // Test 3: 20-cycle stall overflows after 17 held samples; 17..19 dropped.
    clear_stats();
    for (int i = 0; i < 131; i++) begin
      sink_ready = (i >= 20);
      frame_en   = 1'b1;
      adc_valid  = 1'b1;
      adc_data   = DATA_W'(i);
      ovf_clr    = (i == 18);
      tick();
      if (i == 18) check("t3_ovf_beats_clr", fifo_ovf, 1);
    end
    ovf_clr = 1'b0;
    check("t3_ovf_set", fifo_ovf, 1);
    drain("t3_drain", 400);
    frame_checks("t3", 128, 0, 130);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", fifo_ovf, 0);

    // Test 4: frame_en low ignores samples; a one-cycle pulse opens one frame.
    clear_stats();
    for (int i = 0; i < 50; i++) begin
      frame_en = 1'b0; adc_valid = 1'b1; adc_data = DATA_W'(300 + i);
      tick();
    end
    check("t4_quiet_tx", tx_cnt, 0);
    check("t4_quiet_valid", first_valid_cyc, -1);
    frame_en = 1'b1; adc_data = DATA_W'(500);
    tick();
    ramp(200, 501, 1'b0);
    drain("t4_drain", 400);
    frame_checks("t4", 128, 500, 627);
    check("t4_idle_again", busy, 0);

    // Test 5: one-cycle reset after 50 transfers, then a fresh frame.
    clear_stats();
    ramp(52, 0, 1'b1);
    rst_n = 1'b0; adc_valid = 1'b1; adc_data = DATA_W'(99);
    tick();
    check("t5_tx_before_rst", tx_cnt, 50);
    check("t5_rst_outputs", {sink_valid, sink_sop, sink_eop, frame_done, fifo_ovf, busy}, 0);
    check("t5_rst_real", sink_real, 0);
    rst_n = 1'b1; adc_valid = 1'b0;
    clear_stats();
    ramp(128, 200, 1'b1);
    drain("t5_drain", 400);
    frame_checks("t5", 128, 200, 327);

    // Test 6: mid-scale offset-binary word.
    clear_stats();
    frame_en = 1'b1; adc_valid = 1'b1; adc_data = 12'h800;
    tick();
    ramp(127, 1, 1'b1);
    drain("t6_drain", 400);
    check("t6_tx_count", tx_cnt, 128);
`ifdef FEEDER_OFFSET_BIN_EN
    check("t6_sop_value", first_sop, 12'h000);
`else
    check("t6_sop_value", first_sop, 12'h800);
`endif

    // Test 7: back-to-back frames with no gap in the input.
    clear_stats();
    ramp(256, 1000, 1'b1);
    drain("t7_drain", 600);
    frame_checks("t7", 256, 1000, 1255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
